// File: rtl/spm_mul_seq_if.sv
// Handshake/operand bundle for spm_mul_seq. With SPM_SERIAL_OUT_EN defined it
// also carries the serial product stream (y, y_valid).
interface spm_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;
`ifdef SPM_SERIAL_OUT_EN
    logic               y;
    logic               y_valid;

    modport master (output start, signed_mode, a, b, input busy, done, p, y, y_valid);
    modport slave  (input start, signed_mode, a, b, output busy, done, p, y, y_valid);
`else
    modport master (output start, signed_mode, a, b, input busy, done, p);
    modport slave  (input start, signed_mode, a, b, output busy, done, p);
`endif
endinterface

// File: rtl/spm_mul_seq.sv
// Sequential serial-parallel multiplier: a in parallel to a CSA cell chain, b
// shifted in LSB-first, product bits collected into p. Option: SPM_SERIAL_OUT_EN.
module spm_csa_cell (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_cinit,
    input  logic i_en,
    input  logic i_a,
    input  logic i_x,
    input  logic i_neg,
    input  logic i_sin,
    output logic o_y
);
    logic       r_sin;
    logic       r_c;
    logic       w_pp;
    logic [1:0] w_sum;

    // A negated-weight cell adds ~pp; the missing constant comes from i_cinit.
    assign w_pp  = (i_a & i_x) ^ i_neg;
    assign w_sum = {1'b0, w_pp} + {1'b0, r_sin} + {1'b0, r_c};
    assign o_y   = w_sum[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sin <= 1'b0;
            r_c   <= 1'b0;
        end else if (i_clr) begin
            r_sin <= 1'b0;
            r_c   <= i_cinit;
        end else if (i_en) begin
            r_sin <= i_sin;
            r_c   <= w_sum[1];
        end
    end
endmodule

module spm_mul_seq #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(2*WIDTH) + 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    spm_mul_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               r_state, w_next;
    logic                 w_accept;
    logic                 w_run;
    logic                 w_last;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_sm;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_sr;
    logic [2*WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]     w_y;
    logic [WIDTH-1:0]     w_sin;
    logic [WIDTH-1:0]     w_neg;
    logic [WIDTH-1:0]     w_cinit;

    assign w_run  = (r_state == RUN);
    assign w_last = (r_cnt == CNT_W'(2*WIDTH-1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: if (bus.start) begin
                w_accept = 1'b1;
                w_next   = RUN;
            end
            RUN:  if (w_last) w_next = DONE;
            DONE: begin
                w_next = IDLE;
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Top cell carries the two's-complement weight; its carry preload of 1
    // supplies the constant that turns the per-cycle ~pp terms into -pp.
    assign w_sin   = {1'b0, w_y[WIDTH-1:1]};
    assign w_neg   = {r_sm, {(WIDTH-1){1'b0}}};
    assign w_cinit = {bus.signed_mode, {(WIDTH-1){1'b0}}};

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        spm_csa_cell u_cell (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clr   (w_accept),
            .i_cinit (w_cinit[gi]),
            .i_en    (w_run),
            .i_a     (r_a[gi]),
            .i_x     (r_b[0]),
            .i_neg   (w_neg[gi]),
            .i_sin   (w_sin[gi]),
            .o_y     (w_y[gi])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sm  <= 1'b0;
            r_cnt <= '0;
            r_sr  <= '0;
            r_p   <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= bus.a;
                r_b   <= bus.b;
                r_sm  <= bus.signed_mode;
                r_cnt <= '0;
                r_sr  <= '0;
            end else if (w_run) begin
                // b shifts right, refilling with its sign bit in signed mode
                r_b   <= {r_sm & r_b[WIDTH-1], r_b[WIDTH-1:1]};
                r_cnt <= r_cnt + 1'b1;
                r_sr  <= {w_y[0], r_sr[2*WIDTH-1:1]};
            end
            if (w_run && w_last) r_p <= {w_y[0], r_sr[2*WIDTH-1:1]};
        end
    end

    assign bus.busy = w_run;
    assign bus.done = (r_state == DONE);
    assign bus.p    = r_p;
`ifdef SPM_SERIAL_OUT_EN
    assign bus.y       = w_run & w_y[0];
    assign bus.y_valid = w_run;
`endif
endmodule
